// File: rtl/uart_boot_loader_pkg.sv
// rtl/uart_boot_loader_pkg.sv - shared types and constants for the UART boot loader
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } boot_state_e;

    localparam logic [7:0] BOOT_MAGIC     = 8'hB0;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_boot_loader_gap.sv
// rtl/uart_boot_loader_gap.sv - inter-byte gap down-counter, expires after TIMEOUT_CYCLES idle cycles
module boot_gap_timer #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic reload_i,
    output logic expire_o
);
    localparam int              W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]    RELOAD = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0]    ONE    = W'(1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (reload_i) begin
            cnt_q <= RELOAD;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    // Counter sits at 1 during the last allowed idle cycle; a byte in that cycle still wins.
    assign expire_o = en_i && (cnt_q == ONE);

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - loads a framed UART image into SRAM port 0, then hands the port to the SoC
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      soc_ram_en_i,
    input  logic                      soc_ram_we_i,
    input  logic [3:0]                soc_ram_be_i,
    input  logic [RAM_ADDR_WIDTH-1:0] soc_ram_addr_i,
    input  logic [31:0]               soc_ram_wdata_i,
    output logic [31:0]               soc_ram_rdata_o,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    input  logic [31:0]               ram_rdata_i,
    output logic                      core_rst_no,
    output logic                      boot_done_o,
    output logic                      boot_err_o
);
    localparam logic [31:0] MAX_WORDS = 32'd1 << RAM_ADDR_WIDTH;

    boot_state_e               state_q;
    logic [15:0]               len_q;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [1:0]                byte_idx_q;
    logic [23:0]               shift_q;
    logic [7:0]                csum_q;
    logic                      ld_en_q;
    logic                      ld_we_q;
    logic [3:0]                ld_be_q;
    logic [RAM_ADDR_WIDTH-1:0] ld_addr_q;
    logic [31:0]               ld_wdata_q;
    logic                      done_q;
    logic                      err_q;

    logic        gap_en;
    logic        gap_expired;
    logic [15:0] len_full;
    logic [31:0] word_full;
    logic        last_word;

    assign gap_en    = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CSUM);
    assign len_full  = {rx_data_i, len_q[7:0]};
    assign word_full = {rx_data_i, shift_q};
    assign last_word = ({{(32-RAM_ADDR_WIDTH){1'b0}}, addr_q} + 32'd1) == {16'd0, len_q};

    boot_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (gap_en),
        .reload_i (rx_valid_i),
        .expire_o (gap_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            ld_en_q    <= 1'b0;
            ld_we_q    <= 1'b0;
            ld_be_q    <= 4'h0;
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_en_q <= 1'b0;
            ld_we_q <= 1'b0;
            ld_be_q <= 4'h0;
            case (state_q)
                IDLE: begin
                    if (rx_valid_i && rx_data_i == BOOT_MAGIC) begin
                        state_q    <= LEN_LO;
                        err_q      <= 1'b0;
                        csum_q     <= '0;
                        addr_q     <= '0;
                        byte_idx_q <= '0;
                    end
                end
                LEN_LO: begin
                    if (rx_valid_i) begin
                        len_q[7:0] <= rx_data_i;
                        state_q    <= LEN_HI;
                    end else if (gap_expired) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (rx_valid_i) begin
                        len_q[15:8] <= rx_data_i;
                        if (len_full == 16'd0) begin
                            state_q <= CSUM;
                        end else if ({16'd0, len_full} > MAX_WORDS) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end else if (gap_expired) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                DATA: begin
                    if (rx_valid_i) begin
                        csum_q     <= csum_q ^ rx_data_i;
                        shift_q    <= {rx_data_i, shift_q[23:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        // Fourth byte completes the word: strobe it out registered.
                        if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                            ld_en_q    <= 1'b1;
                            ld_we_q    <= 1'b1;
                            ld_be_q    <= 4'hF;
                            ld_addr_q  <= addr_q;
                            ld_wdata_q <= word_full;
                            addr_q     <= addr_q + 1'b1;
                            if (last_word) begin
                                state_q <= CSUM;
                            end
                        end
                    end else if (gap_expired) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                CSUM: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == csum_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end else if (gap_expired) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                DONE:    state_q <= DONE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // After DONE the SoC owns the port with no added latency.
    assign ram_en_o        = done_q ? soc_ram_en_i    : ld_en_q;
    assign ram_we_o        = done_q ? soc_ram_we_i    : ld_we_q;
    assign ram_be_o        = done_q ? soc_ram_be_i    : ld_be_q;
    assign ram_addr_o      = done_q ? soc_ram_addr_i  : ld_addr_q;
    assign ram_wdata_o     = done_q ? soc_ram_wdata_i : ld_wdata_q;
    assign soc_ram_rdata_o = ram_rdata_i;

    assign core_rst_no = done_q & ~rst_i;
    assign boot_done_o = done_q;
    assign boot_err_o  = err_q;

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Loads a firmware image from the UART receive byte stream into the shared SRAM before the CV32E40X core runs. Sits between the SoC RAM port and the SRAM wrapper's port 0. Holds the core in reset while loading, then hands the RAM port to the SoC as a combinational pass-through. Framing: magic byte, 16-bit word count, data words, XOR checksum.

## Interface
- `RAM_ADDR_WIDTH`, 12 — word address width of the SRAM array.
- `TIMEOUT_CYCLES`, 2_500_000 — maximum idle `clk_i` cycles between bytes inside a frame (100 ms at 25 MHz).
- `clk_i` in 1 — system clock. One clock domain only.
- `rst_i` in 1 — reset, synchronous, active-high.
- `rx_valid_i` in 1 — single-cycle strobe from the UART receiver.
- `rx_data_i` in 8 — received byte, valid with `rx_valid_i`.
- `soc_ram_en_i` in 1, `soc_ram_we_i` in 1, `soc_ram_be_i` in 4, `soc_ram_addr_i` in RAM_ADDR_WIDTH, `soc_ram_wdata_i` in 32 — SoC RAM request.
- `soc_ram_rdata_o` out 32 — read data returned to the SoC.
- `ram_en_o` out 1, `ram_we_o` out 1, `ram_be_o` out 4, `ram_addr_o` out RAM_ADDR_WIDTH, `ram_wdata_o` out 32 — request to the SRAM wrapper port 0.
- `ram_rdata_i` in 32 — read data from the SRAM wrapper.
- `core_rst_no` out 1 — active-low core reset. Low until the load succeeds.
- `boot_done_o` out 1 — image loaded and verified.
- `boot_err_o` out 1 — sticky error flag for the last frame.

## Operation
- **Frame format:** `0xB0`, LEN_LO, LEN_HI, then LEN words sent as 4 bytes each, little-endian, then CSUM. CSUM is the XOR of all data bytes only.
- **States and transitions:**
  - IDLE: bytes other than `0xB0` are ignored. `0xB0` goes to LEN_LO and clears `boot_err_o`.
  - LEN_LO → LEN_HI: each captures one byte of the length.
  - After LEN_HI:
    - LEN = 0 → CSUM.
    - LEN > 2^RAM_ADDR_WIDTH → ERR.
    - Otherwise → DATA.
  - DATA: packs bytes into a 32-bit word (byte 0 in bits [7:0]). On the 4th byte, issues a write and increments the word address. After word LEN−1 it goes to CSUM.
  - CSUM: match → DONE, mismatch → ERR.
  - ERR: sets `boot_err_o`, then returns to IDLE on the next cycle. Core stays in reset.
  - DONE: terminal until `rst_i`. All further RX bytes are ignored.
- **Running checksum:** XOR of data bytes, cleared when `0xB0` is accepted in IDLE.
- **Gap timeout:** applies in LEN_LO, LEN_HI, DATA and CSUM. The gap counter reloads on every accepted byte. If `TIMEOUT_CYCLES` cycles pass with no `rx_valid_i`, the block goes to ERR.
- **Port mux:**
  - Before DONE: the RAM outputs come from the loader's registers, and SoC requests are dropped.
  - In DONE: every `ram_*_o` equals the corresponding `soc_ram_*_i`, combinationally.
  - `soc_ram_rdata_o` = `ram_rdata_i` always.
- **Address:** the word address starts at 0 for each frame and is never wrapped. Overflow is impossible because of the LEN check.

## Timing
- **Reset values:**
  - State IDLE.
  - `ram_en_o`, `ram_we_o` = 0; `ram_be_o`, `ram_addr_o`, `ram_wdata_o` = 0.
  - `core_rst_no` = 0, `boot_done_o` = 0, `boot_err_o` = 0.
  - Address, checksum and gap counter = 0.
- **Write latency:** the write strobe is registered. `ram_en_o` = `ram_we_o` = 1 and `ram_be_o` = `4'hF` for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
- **Back-to-back bytes:** bytes on consecutive cycles are accepted. Writes are at least 4 cycles apart, so there is never a write conflict.
- **Release:** `boot_done_o` and `core_rst_no` rise together, one cycle after a matching CSUM byte. The mux switches in that same cycle.
- **`boot_err_o`:** asserted one cycle after the error cause (bad LEN, checksum mismatch or timeout). Held until the next `0xB0` is accepted in IDLE, or until reset.
- **Simultaneous events:** `rx_valid_i` in the cycle the gap counter expires counts as a byte, not a timeout.
- **Reset mid-operation:** takes effect at the next edge. It returns to IDLE and reasserts core reset. SRAM contents written so far are not cleared.

## Structure
- **Package `uart_boot_loader_pkg`:**
  - State enum: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - `BOOT_MAGIC = 8'hB0`.
  - `BYTES_PER_WORD = 4`.
- **Sub-module `boot_gap_timer`:** the reload-on-byte down-counter that asserts expiry. Enable, reload, expire, width `$clog2(TIMEOUT_CYCLES+1)`.
- **Top-level:** instantiated upstream of the SRAM wrapper. The core reset is ANDed with the external reset.

## Test plan
- **Good frame:** B0 02 00, 11 22 33 44, 55 66 77 88, CSUM 0x88.
  - Writes `0x44332211` @0 then `0x88776655` @1, each a 1-cycle strobe with be=F.
  - `boot_done_o` and `core_rst_no` rise 1 cycle after the CSUM byte.
- **Bad checksum:** same frame with CSUM 0x00 → `boot_err_o` = 1, `core_rst_no` stays 0. A following correct frame clears the error and completes.
- **Oversize and empty frames:**
  - LEN = 0x1001 with RAM_ADDR_WIDTH = 12 → ERR, no write strobes.
  - LEN = 0, CSUM 00 → DONE with no writes.
- **Timeout:** stop after 2 data bytes, TIMEOUT_CYCLES = 100 → `boot_err_o` rises at gap cycle 100. A byte arriving exactly at expiry is accepted instead.
- **Pass-through:** after DONE, a SoC write (addr 0x005, be=4'h3, wdata 0xDEADBEEF) appears on `ram_*_o` in the same cycle. `ram_rdata_i` is mirrored on `soc_ram_rdata_o`. RX bytes are ignored.
- **Reset mid-load:** assert `rst_i` during DATA → all outputs return to reset values next edge. A new full frame then loads from address 0.
